// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Instruction-fetch front end. Owns the program counter, drives the
// word-indexed relative address to the instruction memory (which samples it
// on each rising edge and returns the word after that edge), and presents
// fetched instructions with their PC to decode. A one-entry hold buffer
// absorbs decode back-pressure; a branch/jump redirect squashes whatever is
// in flight or held and restarts fetch at the target after a 1-cycle bubble.
//
// Optional feature (compile-time macro FETCH_BOUNDS_CHECK_EN):
//   when defined, an issue with pc > MEM_SIZE is refused and the block
//   enters a sticky FAULT state (if_fault=1, if_valid=0) until a redirect
//   or reset. When undefined, there is no FAULT state, if_fault is 0 and
//   the pc free-runs with 32-bit wrap.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   mem_addr   out  32  relative word address to instruction memory (= pc)
//   mem_instr  in   32  read data for the address sampled at the previous edge
//   if_instr   out  32  instruction to decode
//   if_pc      out  32  relative word address of if_instr
//   if_valid   out  1   if_instr/if_pc valid this cycle
//   if_stall   in   1   decode cannot accept this cycle
//   br_taken   in   1   single-cycle redirect request
//   br_target  in   32  relative word address to fetch after a redirect
//   if_fault   out  1   sticky out-of-bounds fetch flag (0 without the feature)
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] MEM_SIZE = 32'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  input  logic        if_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_fault
);

`ifdef FETCH_BOUNDS_CHECK_EN
  typedef enum logic [1:0] {RUN, HOLD, FAULT} state_t;
`else
  typedef enum logic {RUN, HOLD} state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic        infl;
  logic [31:0] infl_pc;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic        issue;
  logic        capture;

  // The memory always sees the pc register directly, so whatever pc holds at
  // an edge is the word that comes back in the following cycle.
  assign mem_addr = pc;

`ifdef FETCH_BOUNDS_CHECK_EN
  assign if_fault = (state == FAULT);
`else
  // MEM_SIZE only matters to the bounds check; keep it referenced here.
  logic [31:0] unused_mem_size;
  assign unused_mem_size = MEM_SIZE;
  assign if_fault = 1'b0;
`endif

  // Decide what the coming edge does, below the redirect in priority.
  // capture: decode refused a live RUN-state instruction, so park it in the
  // hold buffer (the read launched at that edge is thrown away and the pc is
  // re-fetched when the hold drains). issue: launch a fetch of pc.
  always_comb begin
    capture = 1'b0;
    issue   = 1'b0;
    if (!br_taken) begin
      case (state)
        RUN: begin
          capture = infl && if_stall;
          issue   = !(infl && if_stall);
        end
        HOLD: begin
          issue = !if_stall;
        end
        default: begin
          issue = 1'b0;
        end
      endcase
    end
  end

  // Output mux: in RUN the memory data is passed straight through for the
  // in-flight fetch; in HOLD the parked entry is shown; FAULT shows nothing.
  always_comb begin
    if_valid = 1'b0;
    if_instr = mem_instr;
    if_pc    = infl_pc;
    case (state)
      RUN: begin
        if_valid = infl;
      end
      HOLD: begin
        if_valid = 1'b1;
        if_instr = hold_instr;
        if_pc    = hold_pc;
      end
      default: begin
        if_valid = 1'b0;
      end
    endcase
  end

  // Single state register block. A redirect beats everything, including a
  // stalled HOLD: the squashed entry is simply forgotten and the target goes
  // out on the next edge. A stalled HOLD leaves every register untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      pc         <= RESET_PC;
      infl       <= 1'b0;
      infl_pc    <= 32'd0;
      hold_instr <= 32'd0;
      hold_pc    <= 32'd0;
    end else if (br_taken) begin
      pc    <= br_target;
      infl  <= 1'b0;
      state <= RUN;
    end else if (issue) begin
`ifdef FETCH_BOUNDS_CHECK_EN
      if (pc > MEM_SIZE) begin
        infl  <= 1'b0;
        state <= FAULT;
      end else
`endif
      begin
        infl    <= 1'b1;
        infl_pc <= pc;
        pc      <= pc + 32'd1;
        state   <= RUN;
      end
    end else if (capture) begin
      hold_instr <= mem_instr;
      hold_pc    <= infl_pc;
      infl       <= 1'b0;
      state      <= HOLD;
    end
  end

endmodule
